// File: rtl/mont_exp_ctrl_if.sv
// rtl/mont_exp_ctrl_if.sv - start/operands/done link between the exponentiation controller and a Montgomery multiplier
interface mont_exp_ctrl_if #(
    parameter int WIDTH = 1024
);
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external Montgomery multiplier
module mont_exp_ctrl #(
    parameter int WIDTH   = 1024,
    parameter int E_WIDTH = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [WIDTH-1:0]    in_x,
    input  logic [E_WIDTH-1:0]  in_e,
    input  logic [WIDTH-1:0]    in_m,
    input  logic [WIDTH-1:0]    in_r,
    input  logic [WIDTH-1:0]    in_r2,
    output logic                busy,
    output logic [WIDTH-1:0]    result,
    output logic                done,
    mont_exp_ctrl_if.master     mm
);
    localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        CONV_IN,
        SQR,
        MUL,
        CONV_OUT,
        FIN
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_mm_start;
    logic [WIDTH-1:0]   r_mm_a;
    logic [WIDTH-1:0]   r_mm_b;
    logic [WIDTH-1:0]   r_mm_m;
    logic [WIDTH-1:0]   r_xt;
    logic [WIDTH-1:0]   r_r;
    logic [E_WIDTH-1:0] r_e;
    logic [IW-1:0]      r_idx;

    // ISSUE is the cycle mm_start is high; every other cycle of an op state is WAIT.
    logic               w_accept;
    logic               w_last_bit;
    logic [WIDTH-1:0]   w_step_b;
    state_t             w_step_state;

    assign w_accept     = mm.mm_done && !r_mm_start;
    assign w_last_bit   = (r_idx == '0);
    assign w_step_b     = w_last_bit ? ONE : mm.mm_result;
    assign w_step_state = w_last_bit ? CONV_OUT : SQR;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_mm_start <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_mm_m     <= '0;
            r_xt       <= '0;
            r_r        <= '0;
            r_e        <= '0;
            r_idx      <= '0;
        end else begin
            r_mm_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // x and r2 go straight into the operand registers, so only r, e, m need holding
                        r_e        <= in_e;
                        r_r        <= in_r;
                        r_mm_m     <= in_m;
                        r_mm_a     <= in_x;
                        r_mm_b     <= in_r2;
                        r_mm_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= CONV_IN;
                    end
                end
                CONV_IN: begin
                    if (w_accept) begin
                        r_xt       <= mm.mm_result;
                        r_idx      <= IW'(E_WIDTH - 1);
                        r_mm_a     <= r_r;
                        r_mm_b     <= r_r;
                        r_mm_start <= 1'b1;
                        r_state    <= SQR;
                    end
                end
                SQR: begin
                    if (w_accept) begin
                        r_mm_a     <= mm.mm_result;
                        r_mm_start <= 1'b1;
                        if (r_e[r_idx]) begin
                            r_mm_b  <= r_xt;
                            r_state <= MUL;
                        end else begin
                            r_mm_b  <= w_step_b;
                            r_state <= w_step_state;
                            if (!w_last_bit) r_idx <= r_idx - IW'(1);
                        end
                    end
                end
                MUL: begin
                    if (w_accept) begin
                        r_mm_a     <= mm.mm_result;
                        r_mm_b     <= w_step_b;
                        r_mm_start <= 1'b1;
                        r_state    <= w_step_state;
                        if (!w_last_bit) r_idx <= r_idx - IW'(1);
                    end
                end
                CONV_OUT: begin
                    if (w_accept) begin
                        r_result <= mm.mm_result;
                        r_done   <= 1'b1;
                        r_state  <= FIN;
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign mm.mm_start = r_mm_start;
    assign mm.mm_a     = r_mm_a;
    assign mm.mm_b     = r_mm_b;
    assign mm.mm_m     = r_mm_m;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - scoreboard bench: random modpow runs against a golden model and a behavioural multiplier
module tb_mont_exp_ctrl;
    localparam int W  = 16;
    localparam int EW = 16;

    typedef struct {
        logic [W-1:0] res;
        int           n;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x, in_m, in_r, in_r2;
    logic [EW-1:0] in_e;
    logic          busy, done;
    logic [W-1:0]  result;

    logic          m_done, s_done;
    logic [W-1:0]  m_res;
    bit            lat_rand;

    int            checks = 0;
    int            errors = 0;
    int            starts = 0;
    exp_t          sb[$];

    always #5 clk = ~clk;

    mont_exp_ctrl_if #(.WIDTH(W)) mm_if ();

    assign mm_if.mm_done   = m_done | s_done;
    assign mm_if.mm_result = m_res;

    mont_exp_ctrl #(.WIDTH(W), .E_WIDTH(EW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_x   (in_x),
        .in_e   (in_e),
        .in_m   (in_m),
        .in_r   (in_r),
        .in_r2  (in_r2),
        .busy   (busy),
        .result (result),
        .done   (done),
        .mm     (mm_if.master)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // a*b*2^-W mod m by plain bitwise halving
    function automatic logic [W-1:0] mm_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        longint unsigned v;
        v = 64'(a) * 64'(b);
        for (int k = 0; k < W; k++) begin
            if (v[0]) v = v + 64'(m);
            v = v >> 1;
        end
        return W'(v % 64'(m));
    endfunction

    function automatic logic [W-1:0] modpow(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input logic [W-1:0] m);
        longint unsigned r, b, mm;
        mm = 64'(m);
        r  = 64'd1 % mm;
        b  = 64'(x) % mm;
        for (int k = 0; k < EW; k++) begin
            if (e[k]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return W'(r);
    endfunction

    // behavioural multiplier plus done/start monitor, both on the falling edge
    initial begin : model_monitor
        logic [W-1:0] ca, cb, cm;
        int           cnt;
        bit           pending, unstable, after_done;
        exp_t         ex;
        m_done = 1'b0; m_res = '0; pending = 0; unstable = 0; after_done = 0; cnt = 0;
        ca = '0; cb = '0; cm = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (!resetn) begin
                pending    = 0;
                starts     = 0;
                after_done = 0;
            end else begin
                if (mm_if.mm_start) begin
                    chk("mm_start_while_pending", 64'(pending), 0);
                    starts++;
                    ca = mm_if.mm_a; cb = mm_if.mm_b; cm = mm_if.mm_m;
                    pending  = 1;
                    unstable = 0;
                    cnt      = lat_rand ? int'($urandom_range(1, 20)) : 3;
                end else if (pending) begin
                    if (mm_if.mm_a !== ca || mm_if.mm_b !== cb || mm_if.mm_m !== cm) unstable = 1;
                    cnt--;
                    if (cnt == 0) begin
                        chk("operands_stable", 64'(unstable), 0);
                        m_res   = mm_f(ca, cb, cm);
                        m_done  = 1'b1;
                        pending = 0;
                    end
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        ex = sb.pop_front();
                        chk("result", 64'(result), 64'(ex.res));
                        chk("mult_count", 64'(starts), 64'(ex.n));
                        chk("busy_at_done", 64'(busy), 1);
                    end
                    starts     = 0;
                    after_done = 1;
                end else if (after_done) begin
                    chk("busy_after_done", 64'(busy), 0);
                    after_done = 0;
                end
            end
        end
    end

    task automatic run(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [W-1:0] m,
                       input bit push);
        logic [W-1:0] r, r2;
        int           t;
        exp_t         ex;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 2000);
        if (busy) chk("idle_timeout", 1, 0);
        r  = W'((64'd1 << W) % 64'(m));
        r2 = W'((64'(r) * 64'(r)) % 64'(m));
        in_x = x; in_e = e; in_m = m; in_r = r; in_r2 = r2;
        start = 1'b1;
        if (push) begin
            ex.res = modpow(x, e, m);
            ex.n   = 2 + EW + $countones(e);
            sb.push_back(ex);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 1);
        chk("mm_start_after_start", 64'(mm_if.mm_start), 1);
        chk("conv_in_a", 64'(mm_if.mm_a), 64'(x));
        chk("conv_in_b", 64'(mm_if.mm_b), 64'(r2));
        in_x = W'($urandom); in_e = EW'($urandom); in_m = W'($urandom);
        in_r = W'($urandom); in_r2 = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || busy) chk("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin : stim
        logic [W-1:0]  m, x;
        logic [EW-1:0] e;
        bit            bad;
        int            t;
        resetn = 1'b0; start = 1'b0; s_done = 1'b0; lat_rand = 0;
        in_x = '0; in_e = '0; in_m = '0; in_r = '0; in_r2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_mm_start", 64'(mm_if.mm_start), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_mm_a", 64'(mm_if.mm_a), 0);
        chk("rst_mm_b", 64'(mm_if.mm_b), 0);
        chk("rst_mm_m", 64'(mm_if.mm_m), 0);
        resetn = 1'b1;

        run(16'd5, 16'd3, 16'd13, 1);      drain();
        run(16'd5, 16'd0, 16'd13, 1);      drain();
        run(16'd2, 16'd15, 16'd13, 1);     drain();
        run(16'd2, 16'hFFFF, 16'd13, 1);   drain();

        // start re-pulsed during WAIT must be ignored
        run(16'd5, 16'd3, 16'd13, 1);
        repeat (10) @(negedge clk);
        in_x = 16'd7; in_e = 16'd9; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        drain();
        repeat (3) begin
            @(negedge clk) s_done = 1'b1;
            @(negedge clk) s_done = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("stray_result_held", 64'(result), 8);
        chk("stray_no_mm_start", 64'(starts), 0);
        chk("stray_busy", 64'(busy), 0);

        // reset in SQR WAIT, then a late mm_done
        run(16'd5, 16'd3, 16'd13, 0);
        t = 0;
        while (starts < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (starts < 2) chk("reach_sqr_timeout", 1, 0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_mm_start", 64'(mm_if.mm_start), 0);
        chk("mid_rst_result", 64'(result), 0);
        chk("mid_rst_mm_a", 64'(mm_if.mm_a), 0);
        chk("mid_rst_mm_b", 64'(mm_if.mm_b), 0);
        chk("mid_rst_mm_m", 64'(mm_if.mm_m), 0);
        @(negedge clk);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk) s_done = 1'b1;
        @(negedge clk) s_done = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (mm_if.mm_start || busy || done) bad = 1;
        end
        chk("late_done_ignored", 64'(bad), 0);
        run(16'd5, 16'd3, 16'd13, 1);      drain();

        // back-to-back random runs with random multiplier latency
        lat_rand = 1;
        for (int n = 0; n < 200; n++) begin
            m = W'($urandom_range(3, 65535)) | 16'd1;
            x = W'($urandom % 32'(m));
            e = EW'($urandom);
            run(x, e, m, 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
